spi_ram_bridge: RTL and testbench
=================================

SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

Interface
REQ-001 SHALL have parameter CACHE_EN, default 1, enabling the one-word read buffer (0 = every read goes to RAM).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 mem_addr  input  22  CPU byte address; bits [21:2] = word address, [1:0] ignored.
REQ-005 mem_wdata  input  32  CPU write data, little-endian byte lanes.
REQ-006 mem_wmask  input  4  byte write enables; nonzero in a cycle = write request that cycle.
REQ-007 mem_rstrb  input  1  one-cycle read request.
REQ-008 mem_rdata  output  32  read data; valid in the first cycle mem_rbusy is low after a read.
REQ-009 mem_rbusy  output  1  read in progress.
REQ-010 mem_wbusy  output  1  write in progress.
REQ-011 ram_rstrb, ram_wstrb  output  1 each  one-cycle strobes to the SPI RAM controller.
REQ-012 ram_word_address  output  20; ram_wdata  output  32  to the controller.
REQ-013 ram_rdata  input  32; ram_rbusy, ram_wbusy  input  1 each  from the controller.

Function
REQ-014 States: IDLE, RD_ISSUE, RD_WAIT, RMW_ISSUE, RMW_WAIT, WR_ISSUE, WR_WAIT.
REQ-015 Requests SHALL be sampled only in IDLE; requests in any other state SHALL be ignored.
REQ-016 If mem_wmask!=0 and mem_rstrb in the same cycle, the write SHALL win and the read SHALL be dropped.
REQ-017 Request address, wdata and wmask SHALL be latched on acceptance; later changes of CPU inputs have no effect.
REQ-018 ram_busy = ram_rbusy | ram_wbusy; every *_ISSUE state SHALL last exactly one cycle with its strobe high, then enter the matching *_WAIT state.
REQ-019 A *_WAIT state SHALL exit in the first cycle ram_busy is low; ram_busy is not sampled in the strobe cycle itself.
REQ-020 Read hit (CACHE_EN=1, buffer valid, tag == word address): no RAM access; mem_rdata SHALL be updated at the next edge; mem_rbusy stays low.
REQ-021 Read miss: IDLE->RD_ISSUE->RD_WAIT->IDLE; mem_rbusy SHALL be high from the cycle after acceptance until the RD_WAIT exit edge; mem_rdata and the buffer (data, tag, valid=1) SHALL be loaded from ram_rdata on that edge.
REQ-022 Full write (wmask=4'b1111): IDLE->WR_ISSUE->WR_WAIT->IDLE with ram_wdata = mem_wdata.
REQ-023 Partial write on buffer hit: merge per byte lane (wmask bit set -> new byte, else buffered byte), then WR_ISSUE.
REQ-024 Partial write on miss: RMW_ISSUE (ram_rstrb), RMW_WAIT, merge ram_rdata with latched wdata/wmask, then WR_ISSUE, WR_WAIT.
REQ-025 mem_wbusy SHALL be high from the cycle after write acceptance until the WR_WAIT exit edge.
REQ-026 Every write SHALL leave the buffer holding the merged word with tag = write address and valid=1.
REQ-027 ram_word_address SHALL equal the latched word address whenever a strobe is high; ram_wstrb and ram_rstrb SHALL never be high together.
REQ-028 With CACHE_EN=0 the buffer SHALL never report a hit, and every partial write SHALL take the RMW path.

Reset
REQ-029 On reset: state=IDLE, buffer valid=0, mem_rbusy=0, mem_wbusy=0, ram_rstrb=0, ram_wstrb=0, mem_rdata=0.
REQ-030 Reset during any *_WAIT state SHALL abandon the transfer without issuing further strobes; the in-flight SPI transaction runs out in the controller, and the first post-reset request SHALL not be accepted while ram_busy is high.

Structure
REQ-031 State encodings and the byte-merge function SHALL live in a shared package, spi_ram_pkg, alongside the SPI command opcodes (READ=8'h03, WRITE=8'h02).
REQ-032 The block SHALL be a single module with no sub-modules; the SPI RAM controller is instantiated beside it by the parent, not inside it.

Verification
REQ-033 Read miss at 0x000010, RAM word 0xDEADBEEF -> one ram_rstrb with address 0x00004; mem_rbusy high until done; mem_rdata=0xDEADBEEF.
REQ-034 Repeat read of 0x000010 -> no ram_rstrb; mem_rbusy stays low; mem_rdata=0xDEADBEEF the next cycle.
REQ-035 Write wmask=4'b0010, wdata=0x0000AA00 to uncached 0x000020 holding 0x11223344 -> one ram_rstrb then one ram_wstrb with ram_wdata=0x1122AA44.
REQ-036 Write wmask=4'b1111, wdata=0xCAFEF00D to 0x000010 -> ram_wstrb only, no read; a following read of 0x000010 hits and returns 0xCAFEF00D.
REQ-037 mem_rstrb and mem_wmask=4'b1111 in the same cycle at 0x000030 -> write only, no ram_rstrb; mem_rbusy stays low.
REQ-038 Reset asserted in RD_WAIT -> outputs at reset values the next cycle; a read of the previously cached address misses.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM bridge: FSM encoding, SPI opcodes and the
// byte-lane merge used by partial writes.
package spi_ram_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RMW_ISSUE,
        ST_RMW_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT
    } bridge_state_t;

    // Lanes with mask set take the new byte, others keep the old one.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_ram_bridge.sv
// CPU-side bridge to an SPI RAM controller: one-word write-through read buffer,
// read-modify-write for partial writes that miss the buffer.
module spi_ram_bridge
    import spi_ram_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        ram_rstrb,
    output logic        ram_wstrb,
    output logic [19:0] ram_word_address,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rbusy,
    input  logic        ram_wbusy
);

    bridge_state_t state, state_nxt;

    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic [31:0] wr_data;

    logic [31:0] buf_data;
    logic [19:0] buf_tag;
    logic        buf_valid;

    logic [19:0] req_word;
    logic        ram_busy;
    logic        buf_hit;
    logic        wr_req;
    logic        rd_req;
    logic        accept;
    logic        unused_byte_offset;

    assign unused_byte_offset = ^mem_addr[1:0];

    assign req_word = mem_addr[21:2];
    assign ram_busy = ram_rbusy | ram_wbusy;
    assign buf_hit  = (CACHE_EN != 0) && buf_valid && (buf_tag == req_word);
    assign wr_req   = |mem_wmask;
    assign rd_req   = mem_rstrb && !wr_req;
    // A transfer abandoned by reset may still be running in the controller;
    // hold off new work until it drains.
    assign accept   = (state == ST_IDLE) && !ram_busy;

    assign mem_rbusy        = (state == ST_RD_ISSUE) || (state == ST_RD_WAIT);
    assign mem_wbusy        = (state == ST_RMW_ISSUE) || (state == ST_RMW_WAIT) ||
                              (state == ST_WR_ISSUE)  || (state == ST_WR_WAIT);
    assign ram_rstrb        = (state == ST_RD_ISSUE) || (state == ST_RMW_ISSUE);
    assign ram_wstrb        = (state == ST_WR_ISSUE);
    assign ram_word_address = req_addr;
    assign ram_wdata        = wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && wr_req) begin
                    state_nxt = (mem_wmask == 4'hF || buf_hit) ? ST_WR_ISSUE : ST_RMW_ISSUE;
                end else if (accept && rd_req && !buf_hit) begin
                    state_nxt = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:   if (!ram_busy) state_nxt = ST_IDLE;
            ST_RMW_ISSUE: state_nxt = ST_RMW_WAIT;
            ST_RMW_WAIT:  if (!ram_busy) state_nxt = ST_WR_ISSUE;
            ST_WR_ISSUE:  state_nxt = ST_WR_WAIT;
            ST_WR_WAIT:   if (!ram_busy) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
            wr_data   <= '0;
            buf_data  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && wr_req) begin
                        req_addr  <= req_word;
                        req_wdata <= mem_wdata;
                        req_wmask <= mem_wmask;
                        // Full writes and buffer hits have every byte on hand now.
                        if (mem_wmask == 4'hF || buf_hit) begin
                            wr_data   <= merge_bytes(buf_data, mem_wdata, mem_wmask);
                            buf_data  <= merge_bytes(buf_data, mem_wdata, mem_wmask);
                            buf_tag   <= req_word;
                            buf_valid <= 1'b1;
                        end
                    end else if (accept && rd_req) begin
                        req_addr <= req_word;
                        if (buf_hit) mem_rdata <= buf_data;
                    end
                end
                ST_RD_WAIT: begin
                    if (!ram_busy) begin
                        mem_rdata <= ram_rdata;
                        buf_data  <= ram_rdata;
                        buf_tag   <= req_addr;
                        buf_valid <= 1'b1;
                    end
                end
                ST_RMW_WAIT: begin
                    if (!ram_busy) begin
                        wr_data   <= merge_bytes(ram_rdata, req_wdata, req_wmask);
                        buf_data  <= merge_bytes(ram_rdata, req_wdata, req_wmask);
                        buf_tag   <= req_addr;
                        buf_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Self-checking bench for spi_ram_bridge: a behavioural SPI RAM controller with
// variable latency plus a word-level memory/buffer reference model.
module tb_spi_ram_bridge;

    localparam int CACHE_EN = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy, mem_wbusy;
    logic        ram_rstrb, ram_wstrb;
    logic [19:0] ram_word_address;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_rbusy, ram_wbusy;

    always #5 clk = ~clk;

    spi_ram_bridge #(.CACHE_EN(CACHE_EN)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
        .ram_rstrb(ram_rstrb), .ram_wstrb(ram_wstrb),
        .ram_word_address(ram_word_address), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy)
    );

    int total = 0;
    int bad   = 0;

    // Controller model: busy for lat_cfg cycles after each strobe, ignores bridge reset.
    logic [31:0] ram_mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [19:0] r_addr = '0;
    int r_cnt = 0, w_cnt = 0, lat_cfg = 2;
    int n_rstrb = 0, n_wstrb = 0, n_both = 0;
    logic [19:0] last_raddr = '0, last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        c_valid = 1'b0;
    logic [19:0] c_tag = '0;

    always @(posedge clk) begin
        if (ram_rstrb && ram_wstrb) n_both++;
        if (ram_rstrb) begin
            n_rstrb++;
            last_raddr = ram_word_address;
            r_addr <= ram_word_address;
            r_cnt  <= lat_cfg;
        end else if (r_cnt > 0) begin
            r_cnt <= r_cnt - 1;
        end
        if (ram_wstrb) begin
            n_wstrb++;
            last_waddr = ram_word_address;
            last_wdata = ram_wdata;
            ram_mem[ram_word_address[7:0]] = ram_wdata;
            w_cnt <= lat_cfg;
        end else if (w_cnt > 0) begin
            w_cnt <= w_cnt - 1;
        end
    end

    assign ram_rbusy = (r_cnt != 0);
    assign ram_wbusy = (w_cnt != 0);
    assign ram_rdata = ram_mem[r_addr[7:0]];

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // One-cycle CPU request, then scramble the CPU bus and wait for busy to clear.
    task automatic do_req(input logic [21:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic rs, output logic rb0, output logic wb0, output logic tout);
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = rs;
        @(negedge clk);
        mem_wmask = 4'h0; mem_rstrb = 1'b0;
        mem_addr = 22'($urandom); mem_wdata = $urandom;
        rb0 = mem_rbusy; wb0 = mem_wbusy;
        for (int i = 0; i < 100 && (mem_rbusy || mem_wbusy); i++) @(negedge clk);
        tout = mem_rbusy || mem_wbusy;
    endtask

    task automatic wait_ram_idle(output logic tout);
        for (int i = 0; i < 100 && (ram_rbusy || ram_wbusy); i++) @(negedge clk);
        tout = ram_rbusy || ram_wbusy;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({mem_rbusy, mem_wbusy, ram_rstrb, ram_wstrb, mem_rdata} !== 36'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {mem_rbusy, mem_wbusy, ram_rstrb, ram_wstrb, mem_rdata}); end
        reset = 1'b0;
        c_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic rb0, wb0, tout;
        int nr, nw;
        ram_mem[4] = 32'hDEADBEEF;
        ram_mem[8] = 32'h11223344;
        lat_cfg = 2;
        // read miss
        nr = n_rstrb;
        do_req(22'h000010, 32'h0, 4'h0, 1'b1, rb0, wb0, tout);
        total++; if (n_rstrb - nr != 1 || last_raddr !== 20'h00004) begin bad++; $display("FAIL rd_miss_strobe count=%0d addr=%h want 1 @00004", n_rstrb - nr, last_raddr); end
        total++; if (rb0 !== 1'b1 || tout) begin bad++; $display("FAIL rd_miss_busy rbusy=%b timeout=%b want 1/0", rb0, tout); end
        total++; if (mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_miss_data got=%h want=deadbeef", mem_rdata); end
        // read hit
        nr = n_rstrb;
        do_req(22'h000010, 32'h0, 4'h0, 1'b1, rb0, wb0, tout);
        total++; if (n_rstrb != nr || rb0 !== 1'b0 || mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hit strobes=%0d rbusy=%b data=%h want 0/0/deadbeef", n_rstrb - nr, rb0, mem_rdata); end
        // partial write miss -> read-modify-write
        nr = n_rstrb; nw = n_wstrb;
        do_req(22'h000020, 32'h0000AA00, 4'b0010, 1'b0, rb0, wb0, tout);
        total++; if (n_rstrb - nr != 1 || n_wstrb - nw != 1 || wb0 !== 1'b1 || tout) begin bad++; $display("FAIL rmw_ctrl rd=%0d wr=%0d wbusy=%b want 1/1/1", n_rstrb - nr, n_wstrb - nw, wb0); end
        total++; if (last_wdata !== 32'h1122AA44 || last_waddr !== 20'h00008) begin bad++; $display("FAIL rmw_data got=%h@%h want=1122aa44@00008", last_wdata, last_waddr); end
        // full write, then hit on the written word
        nr = n_rstrb; nw = n_wstrb;
        do_req(22'h000010, 32'hCAFEF00D, 4'hF, 1'b0, rb0, wb0, tout);
        total++; if (n_rstrb != nr || n_wstrb - nw != 1 || ram_mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL full_wr rd=%0d wr=%0d mem=%h want 0/1/cafef00d", n_rstrb - nr, n_wstrb - nw, ram_mem[4]); end
        do_req(22'h000010, 32'h0, 4'h0, 1'b1, rb0, wb0, tout);
        total++; if (n_rstrb != nr || rb0 !== 1'b0 || mem_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL wr_then_hit rd=%0d rbusy=%b data=%h want 0/0/cafef00d", n_rstrb - nr, rb0, mem_rdata); end
        // simultaneous read and write: write wins
        nr = n_rstrb; nw = n_wstrb;
        do_req(22'h000030, 32'h5A5A1234, 4'hF, 1'b1, rb0, wb0, tout);
        total++; if (n_rstrb != nr || n_wstrb - nw != 1 || rb0 !== 1'b0 || ram_mem[12] !== 32'h5A5A1234) begin bad++; $display("FAIL wr_wins rd=%0d wr=%0d rbusy=%b mem=%h want 0/1/0/5a5a1234", n_rstrb - nr, n_wstrb - nw, rb0, ram_mem[12]); end
    endtask

    task automatic test_random();
        logic rb0, wb0, tout, hit;
        logic [31:0] d, merged;
        logic [3:0] m;
        logic rs;
        int w, kind, nr, nw, exp_rd;
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
        c_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = $urandom; ref_mem[i] = ram_mem[i];
        end
        for (int n = 0; n < 60; n++) begin
            w = $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            d = $urandom;
            m = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
            rs = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            lat_cfg = $urandom_range(1, 4);
            hit = (CACHE_EN != 0) && c_valid && (c_tag == 20'(w));
            nr = n_rstrb; nw = n_wstrb;
            do_req(22'(w * 4 + $urandom_range(0, 3)), d, m, rs, rb0, wb0, tout);
            if (kind == 0) begin
                exp_rd = hit ? 0 : 1;
                total++; if (n_rstrb - nr != exp_rd || n_wstrb != nw || rb0 !== !hit || wb0 !== 1'b0 || tout) begin bad++; $display("FAIL rand_rd_ctrl op=%0d rd=%0d wr=%0d rbusy=%b to=%b want rd=%0d rbusy=%b", n, n_rstrb - nr, n_wstrb - nw, rb0, tout, exp_rd, !hit); end
                total++; if (mem_rdata !== ref_mem[w]) begin bad++; $display("FAIL rand_rd_data op=%0d got=%h want=%h", n, mem_rdata, ref_mem[w]); end
            end else begin
                exp_rd = (m != 4'hF && !hit) ? 1 : 0;
                merged = ref_merge(ref_mem[w], d, m);
                ref_mem[w] = merged;
                total++; if (n_rstrb - nr != exp_rd || n_wstrb - nw != 1 || rb0 !== 1'b0 || wb0 !== 1'b1 || tout) begin bad++; $display("FAIL rand_wr_ctrl op=%0d rd=%0d wr=%0d rbusy=%b wbusy=%b to=%b want rd=%0d wr=1", n, n_rstrb - nr, n_wstrb - nw, rb0, wb0, tout, exp_rd); end
                total++; if (last_wdata !== merged || last_waddr !== 20'(w) || ram_mem[w] !== merged) begin bad++; $display("FAIL rand_wr_data op=%0d got=%h@%h want=%h@%h", n, last_wdata, last_waddr, merged, 20'(w)); end
            end
            c_valid = 1'b1; c_tag = 20'(w);
        end
    endtask

    task automatic test_ignored();
        logic tout;
        logic [19:0] w1;
        int nw;
        w1 = (c_valid && c_tag == 20'd3) ? 20'd5 : 20'd3;
        lat_cfg = 4;
        nw = n_wstrb;
        @(negedge clk); mem_addr = {w1, 2'b00}; mem_rstrb = 1'b1;
        @(negedge clk); mem_rstrb = 1'b0;
        @(negedge clk); mem_addr = {20'd9, 2'b00}; mem_wdata = $urandom; mem_wmask = 4'hF;
        @(negedge clk); mem_wmask = 4'h0;
        for (int i = 0; i < 100 && mem_rbusy; i++) @(negedge clk);
        wait_ram_idle(tout);
        total++; if (n_wstrb != nw || ram_mem[9] !== ref_mem[9] || tout) begin bad++; $display("FAIL busy_ignore wr=%0d mem=%h want 0/%h", n_wstrb - nw, ram_mem[9], ref_mem[9]); end
        total++; if (mem_rdata !== ref_mem[w1]) begin bad++; $display("FAIL busy_read_data got=%h want=%h", mem_rdata, ref_mem[w1]); end
        c_valid = 1'b1; c_tag = w1;
    endtask

    task automatic test_reset_in_wait();
        logic rb0, wb0, tout;
        int nr;
        lat_cfg = 2;
        do_req({20'd2, 2'b00}, 32'h0, 4'h0, 1'b1, rb0, wb0, tout);
        lat_cfg = 8;
        @(negedge clk); mem_addr = {20'd6, 2'b00}; mem_rstrb = 1'b1;
        @(negedge clk); mem_rstrb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({mem_rbusy, mem_wbusy, ram_rstrb, ram_wstrb, mem_rdata} !== 36'h0) begin bad++; $display("FAIL reset_in_wait got=%h want=0", {mem_rbusy, mem_wbusy, ram_rstrb, ram_wstrb, mem_rdata}); end
        reset = 1'b0;
        c_valid = 1'b0;
        nr = n_rstrb;
        do_req({20'd2, 2'b00}, 32'h0, 4'h0, 1'b1, rb0, wb0, tout);
        total++; if (n_rstrb != nr || rb0 !== 1'b0 || mem_rdata !== 32'h0) begin bad++; $display("FAIL req_while_ram_busy rd=%0d rbusy=%b data=%h want 0/0/0", n_rstrb - nr, rb0, mem_rdata); end
        wait_ram_idle(tout);
        lat_cfg = 2;
        do_req({20'd2, 2'b00}, 32'h0, 4'h0, 1'b1, rb0, wb0, tout);
        total++; if (n_rstrb - nr != 1 || rb0 !== 1'b1 || mem_rdata !== ref_mem[2] || tout) begin bad++; $display("FAIL post_reset_miss rd=%0d rbusy=%b data=%h want 1/1/%h", n_rstrb - nr, rb0, mem_rdata, ref_mem[2]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0; ref_mem[i] = '0;
        end
        test_reset();
        test_directed();
        test_random();
        test_ignored();
        test_reset_in_wait();
        total++; if (n_both != 0) begin bad++; $display("FAIL strobe_overlap count=%0d want 0", n_both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
